// File: rtl/fadd_norm_round.sv
// Post-add normalise / round-to-nearest-even / pack stage for a single-precision adder.
// One operation in flight; valid/ready on both sides, result held in DONE until taken.
module fadd_norm_round #(
    parameter bit FAST_LZ      = 1'b0,
    parameter bit FLUSH_DENORM = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [27:0] in_sum,
    input  logic        in_special,
    input  logic [31:0] in_special_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_overflow,
    output logic        out_underflow
);

    // state | meaning
    // IDLE  | waiting for an operation
    // SHIFT | left-normalising toward the hidden bit, floored at exp==1
    // ROUND | round-to-nearest-even, carry renormalise, overflow check, pack
    // DONE  | result presented until out_ready
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ROUND, S_DONE} state_t;

    state_t             r_state;
    logic               r_sign;
    logic signed [9:0]  r_exp;
    logic [27:0]        r_sum;
    logic               r_sub;
    logic [31:0]        r_result;
    logic               r_ovf;
    logic               r_unf;
    logic               r_out_valid;

    logic               w_accept;
    logic signed [9:0]  w_in_exp;
    logic [4:0]         w_lz;
    logic signed [9:0]  w_lim;
    logic [4:0]         w_amt;
    logic [27:0]        w_sum_sh;
    logic signed [9:0]  w_exp_sh;
    logic [23:0]        w_m24;
    logic               w_up;
    logic [24:0]        w_m25;
    logic               w_carry;
    logic signed [9:0]  w_exp_rnd;
    logic [22:0]        w_man;

    assign in_ready      = rst_n & ((r_state == S_IDLE) | ((r_state == S_DONE) & out_ready));
    assign w_accept      = in_valid & in_ready;
    assign w_in_exp      = signed'({2'b00, in_exp});

    assign out_valid     = r_out_valid;
    assign out_result    = r_result;
    assign out_overflow  = r_ovf;
    assign out_underflow = r_unf;

    // Distance from the leading one to the hidden-bit position.
    always_comb begin
        w_lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (r_sum[i]) w_lz = 5'(26 - i);
        end
    end

    assign w_lim = r_exp - 10'sd1;

    always_comb begin
        w_amt = 5'd1;
        if (FAST_LZ) begin
            if (w_lim < signed'({5'd0, w_lz})) w_amt = w_lim[4:0];
            else                               w_amt = w_lz;
        end
    end

    assign w_sum_sh  = r_sum << w_amt;
    assign w_exp_sh  = r_exp - signed'({5'd0, w_amt});

    assign w_m24     = r_sum[26:3];
    assign w_up      = r_sum[2] & (r_sum[1] | r_sum[0] | r_sum[3]);
    assign w_m25     = {1'b0, w_m24} + {24'd0, w_up};
    assign w_carry   = w_m25[24];
    assign w_exp_rnd = r_exp + signed'({9'd0, w_carry});
    assign w_man     = w_carry ? 23'd0 : w_m25[22:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_sum       <= '0;
            r_sub       <= 1'b0;
            r_result    <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_sign      <= in_sign;
                        r_exp       <= w_in_exp;
                        r_sum       <= in_sum;
                        r_sub       <= 1'b0;
                        r_ovf       <= 1'b0;
                        r_unf       <= 1'b0;
                        r_out_valid <= 1'b0;
                        if (in_special) begin
                            r_result    <= in_special_val;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else if (in_sum == 28'd0) begin
                            r_result    <= 32'h0000_0000;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else if (in_sum[27]) begin
                            // Bit shifted out of the carry position folds into sticky.
                            r_sum   <= {1'b0, in_sum[27:2], in_sum[1] | in_sum[0]};
                            r_exp   <= w_in_exp + 10'sd1;
                            r_state <= S_ROUND;
                        end else if (in_sum[26]) begin
                            r_state <= S_ROUND;
                        end else if (w_in_exp <= 10'sd1) begin
                            if (FLUSH_DENORM) begin
                                r_result    <= {in_sign, 31'd0};
                                r_unf       <= 1'b1;
                                r_out_valid <= 1'b1;
                                r_state     <= S_DONE;
                            end else begin
                                r_sub   <= 1'b1;
                                r_state <= S_ROUND;
                            end
                        end else begin
                            r_state <= S_SHIFT;
                        end
                    end else if ((r_state == S_DONE) && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                S_SHIFT: begin
                    r_sum <= w_sum_sh;
                    r_exp <= w_exp_sh;
                    if (w_sum_sh[26]) begin
                        r_state <= S_ROUND;
                    end else if (w_exp_sh <= 10'sd1) begin
                        if (FLUSH_DENORM) begin
                            r_result    <= {r_sign, 31'd0};
                            r_unf       <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_sub   <= 1'b1;
                            r_state <= S_ROUND;
                        end
                    end
                end

                S_ROUND: begin
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                    // A subnormal that rounds up into the hidden bit lands as exp field 1.
                    if (r_sub) begin
                        r_result <= {r_sign, 7'd0, w_m25[23:0]};
                        r_unf    <= 1'b1;
                    end else if (w_exp_rnd >= 10'sd255) begin
                        r_result <= {r_sign, 8'hFF, 23'd0};
                        r_ovf    <= 1'b1;
                    end else begin
                        r_result <= {r_sign, w_exp_rnd[7:0], w_man};
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
